// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    typedef logic [N_REQ-1:0] req_vec_t;

endpackage

// File: rtl/onehot_dec3to8.sv
// 3-to-8 one-hot decoder with an enable; output is all-zero when disabled.
module onehot_dec3to8 (
    input  logic       en,
    input  logic [2:0] idx,
    output logic [7:0] onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_dec
            assign onehot[gi] = en && (idx == 3'(gi));
        end
    endgenerate

endmodule

// File: rtl/rr_prio_pick.sv
// Rotating priority pick: first set request at or above ptr, wrapping modulo 8.
// Works by rotating req so ptr lands at bit 0, taking the lowest set bit,
// then adding ptr back to recover the absolute index.
module rr_prio_pick
    import arb_pkg::*;
(
    input  req_vec_t          req,
    input  logic [IDX_W-1:0]  ptr,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    req_vec_t         rot;
    logic [IDX_W-1:0] rot_idx;

    // Rotate so that position ptr becomes bit 0; the 3-bit add wraps naturally.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign rot[gi] = req[3'(gi) + ptr];
        end
    endgenerate

    // Fixed priority on the rotated vector: lowest set bit wins.
    always_comb begin
        rot_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = 3'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = rot_idx + ptr;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with bounded hold and a mandatory
// one-cycle gap between consecutive grants.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  req_vec_t         req,
    output req_vec_t         gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             preempt
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);

    arb_state_t       state_reg;
    logic [IDX_W-1:0] ptr_reg;
    logic [7:0]       hold_cnt_reg;
    logic [IDX_W-1:0] gnt_idx_reg;
    logic             gnt_valid_reg;
    logic             preempt_reg;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    rr_prio_pick u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Arbitration FSM; all outputs come straight from these registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            hold_cnt_reg  <= '0;
            gnt_idx_reg   <= '0;
            gnt_valid_reg <= 1'b0;
            preempt_reg   <= 1'b0;
        end else begin
            case (state_reg)
                GRANT: begin
                    if (!req[gnt_idx_reg]) begin
                        // Normal release wins even when the limit is reached.
                        state_reg     <= GAP;
                        gnt_valid_reg <= 1'b0;
                        gnt_idx_reg   <= '0;
                        hold_cnt_reg  <= '0;
                        preempt_reg   <= 1'b0;
                    end else if (hold_cnt_reg >= HOLD_LIMIT) begin
                        state_reg     <= GAP;
                        gnt_valid_reg <= 1'b0;
                        gnt_idx_reg   <= '0;
                        hold_cnt_reg  <= '0;
                        preempt_reg   <= 1'b1;
                    end else begin
                        hold_cnt_reg  <= hold_cnt_reg + 8'd1;
                        preempt_reg   <= 1'b0;
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; ptr already points
                    // past the last winner, so it gets lowest priority.
                    preempt_reg <= 1'b0;
                    if (pick_found) begin
                        state_reg     <= GRANT;
                        gnt_idx_reg   <= pick_idx;
                        gnt_valid_reg <= 1'b1;
                        hold_cnt_reg  <= 8'd1;
                        ptr_reg       <= pick_idx + 3'd1;
                    end else begin
                        state_reg     <= IDLE;
                        gnt_idx_reg   <= '0;
                        gnt_valid_reg <= 1'b0;
                        hold_cnt_reg  <= '0;
                    end
                end
            endcase
        end
    end

    onehot_dec3to8 u_dec (
        .en     (gnt_valid_reg),
        .idx    (gnt_idx_reg),
        .onehot (gnt)
    );

    assign gnt_idx   = gnt_idx_reg;
    assign gnt_valid = gnt_valid_reg;
    assign preempt   = preempt_reg;

endmodule
